// File: rtl/ring_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : ring_freq_meter
// Description : Measures a free-running ring oscillator from the system clock
//               domain. The asynchronous ring output passes through a two-flop
//               synchronizer and an edge detector. Rising edges are then
//               counted, with saturation, over a gate window of WINDOW clk
//               cycles. The result is offered on a valid/ready handshake.
//
// Parameters  : WINDOW    gate length in clk cycles (2 .. 2^24)
//               CNT_W     width of the edge counter / count output
//
// Ports       : clk        system clock
//               rst_b      asynchronous active-low reset
//               ring_in    ring oscillator output (asynchronous to clk)
//               start      request a measurement (sampled only when idle)
//               busy       high whenever a measurement or result is pending
//               cnt_valid  result available
//               cnt_ready  consumer accepts the result
//               count      rising edges seen in the last window (saturating)
//               overflow   count saturated during the last window
//
// Revision    : 1.0 - initial release
// ============================================================================
module ring_freq_meter #(
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             ring_in,
    input  logic             start,
    output logic             busy,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int               c_TMR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MEASURE = 2'd1;
    localparam logic [1:0] c_ST_HOLD    = 2'd2;

    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic               w_edge_p;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    // Synchronizer (r_s1, r_s2) plus history flop r_s3 for edge detection.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= ring_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge_p = r_s2 & ~r_s3;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        cnt_valid   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_MEASURE;
                end
            end
            c_ST_MEASURE: begin
                busy = 1'b1;
                if (r_timer == c_TMR_LAST) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                busy      = 1'b1;
                cnt_valid = 1'b1;
                if (cnt_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Window timer, edge counter and overflow flag. The counter and flag are
    // only cleared by an accepted start, so the last result stays visible in
    // IDLE until the next measurement begins.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_timer    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_timer    <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                c_ST_MEASURE: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_edge_p) begin
                        if (r_count == c_CNT_MAX) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ring_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_freq_meter
// Description : Directed self-checking bench for ring_freq_meter. A main
//               instance (WINDOW=16, CNT_W=16) covers latency, exact counting,
//               back-pressure, back-to-back and reset abort; a second instance
//               (WINDOW=64, CNT_W=3) covers saturation. The ring is modelled
//               as a clk-synchronous square wave of period 4 (2 high, 2 low).
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_freq_meter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        ring_en;
    logic [1:0]  ring_ph = 2'd0;
    logic        ring_in;
    logic        start;
    logic        cnt_ready;
    logic        busy;
    logic        cnt_valid;
    logic [15:0] count;
    logic        overflow;
    logic        start_s;
    logic        cnt_ready_s;
    logic        busy_s;
    logic        cnt_valid_s;
    logic [2:0]  count_s;
    logic        overflow_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ring_ph <= ring_ph + 2'd1;
    assign ring_in = ring_en & ring_ph[1];

    ring_freq_meter #(.WINDOW(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .ring_in   (ring_in),
        .start     (start),
        .busy      (busy),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .count     (count),
        .overflow  (overflow)
    );

    ring_freq_meter #(.WINDOW(64), .CNT_W(3)) dut_sat (
        .clk       (clk),
        .rst_b     (rst_b),
        .ring_in   (ring_in),
        .start     (start_s),
        .busy      (busy_s),
        .cnt_valid (cnt_valid_s),
        .cnt_ready (cnt_ready_s),
        .count     (count_s),
        .overflow  (overflow_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the main instance; lat = cycles from the start edge to
    // the first cycle with cnt_valid high (bounded).
    task automatic launch(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!cnt_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        #2;
        total++;
        if (busy !== 1'b0 || cnt_valid !== 1'b0 || count !== 16'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_main: busy=%b valid=%b count=%0d ovf=%b want 0/0/0/0",
                     busy, cnt_valid, count, overflow);
        end
        total++;
        if (busy_s !== 1'b0 || cnt_valid_s !== 1'b0 || count_s !== 3'd0 || overflow_s !== 1'b0) begin
            bad++;
            $display("FAIL reset_sat: busy=%b valid=%b count=%0d ovf=%b want 0/0/0/0",
                     busy_s, cnt_valid_s, count_s, overflow_s);
        end
        tick();
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_ring_static;
        int lat;
        ring_en = 1'b0;
        repeat (4) tick();
        launch(lat);
        total++;
        if (lat !== 17) begin
            bad++;
            $display("FAIL static_latency: got %0d want 17", lat);
        end
        total++;
        if (count !== 16'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL static_count: count=%0d ovf=%b want 0/0", count, overflow);
        end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        total++;
        if (cnt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL static_handshake: valid=%b busy=%b want 0/0", cnt_valid, busy);
        end
    endtask

    task automatic test_exact_count;
        int lat;
        ring_en = 1'b1;
        repeat (8) tick();
        launch(lat);
        total++;
        if (lat !== 17) begin
            bad++;
            $display("FAIL exact_latency: got %0d want 17", lat);
        end
        total++;
        if (count !== 16'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL exact_count: count=%0d ovf=%b want 4/0", count, overflow);
        end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        repeat (5) tick();
        total++;
        if (count !== 16'd4 || busy !== 1'b0 || cnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL exact_retain: count=%0d busy=%b valid=%b want 4/0/0",
                     count, busy, cnt_valid);
        end
    endtask

    task automatic test_back_pressure;
        int lat;
        launch(lat);
        total++;
        if (lat !== 17) begin
            bad++;
            $display("FAIL bp_latency: got %0d want 17", lat);
        end
        cnt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
            total++;
            if (cnt_valid !== 1'b1 || busy !== 1'b1 || count !== 16'd4) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b busy=%b count=%0d want 1/1/4",
                         i, cnt_valid, busy, count);
            end
        end
        start     = 1'b0;
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        total++;
        if (cnt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: valid=%b busy=%b want 0/0", cnt_valid, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_start_queued: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(lat);
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        start     = 1'b1;
        total++;
        if (cnt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: valid=%b busy=%b want 0/0", cnt_valid, busy);
        end
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b want 1", busy);
        end
        lat = 1;
        while (!cnt_valid && lat < 200) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 17) begin
            bad++;
            $display("FAIL b2b_latency: got %0d want 17", lat);
        end
        total++;
        if (count !== 16'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count: count=%0d ovf=%b want 4/0", count, overflow);
        end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
    endtask

    task automatic test_saturation;
        int lat;
        ring_en = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        lat = 1;
        while (!cnt_valid_s && lat < 300) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 65) begin
            bad++;
            $display("FAIL sat_latency: got %0d want 65", lat);
        end
        total++;
        if (count_s !== 3'd7 || overflow_s !== 1'b1) begin
            bad++;
            $display("FAIL sat_count: count=%0d ovf=%b want 7/1", count_s, overflow_s);
        end
        cnt_ready_s = 1'b1;
        tick();
        cnt_ready_s = 1'b0;
        total++;
        if (cnt_valid_s !== 1'b0 || count_s !== 3'd7 || overflow_s !== 1'b1) begin
            bad++;
            $display("FAIL sat_retain: valid=%b count=%0d ovf=%b want 0/7/1",
                     cnt_valid_s, count_s, overflow_s);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        ring_en = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        total++;
        if (busy !== 1'b1 || cnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_precond: busy=%b valid=%b want 1/0", busy, cnt_valid);
        end
        #1;
        rst_b = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || cnt_valid !== 1'b0 || count !== 16'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_main: busy=%b valid=%b count=%0d ovf=%b want 0/0/0/0",
                     busy, cnt_valid, count, overflow);
        end
        total++;
        if (count_s !== 3'd0 || overflow_s !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_sat: count=%0d ovf=%b want 0/0", count_s, overflow_s);
        end
        #1;
        rst_b = 1'b1;
        tick();
        tick();
        launch(lat);
        total++;
        if (lat !== 17) begin
            bad++;
            $display("FAIL mid_relaunch_latency: got %0d want 17", lat);
        end
        total++;
        if (count !== 16'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_relaunch_count: count=%0d ovf=%b want 4/0", count, overflow);
        end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
    endtask

    initial begin
        rst_b       = 1'b0;
        ring_en     = 1'b0;
        start       = 1'b0;
        cnt_ready   = 1'b0;
        start_s     = 1'b0;
        cnt_ready_s = 1'b0;
        test_reset();
        test_ring_static();
        test_exact_count();
        test_back_pressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
